// File: rtl/u_seqdiv16_8.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor -> N-bit quotient and remainder.
// One quotient bit per clock; overflow and divide-by-zero finish in a single cycle.
module u_seqdiv16_8 #(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [2*N-1:0] a,
   input  logic [N-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [N-1:0]   q,
   output logic [N-1:0]   r,
   output logic           ovf,
   output logic           div0
);

   // Handshake: start is taken on any rising edge where busy=0 (IDLE or DONE);
   // done is a one-cycle pulse and q/r/ovf/div0 hold until the next done or reset.

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_t        state, state_nxt;
   logic [N:0]    p;
   logic [N-1:0]  lo_sr;
   logic [N-1:0]  quo;
   logic [N-1:0]  b_reg;
   logic [CW-1:0] cnt;

   logic          accept, early, step, finish;
   logic          hi_ge_b;

   logic [N:0]    t;
   logic [N:0]    bn;
   logic [N:0]    diff;
   logic [N+1:0]  carry;
   logic          ge;
   logic [N:0]    p_nxt;
   logic [N-1:0]  quo_nxt;

   assign hi_ge_b = (a[2*N-1:N] >= b);

   // Compare-subtract: T + ~{0,b} + 1 as one ripple chain; carry out means T >= b.
   assign t        = {p[N-1:0], lo_sr[N-1]};
   assign bn       = ~{1'b0, b_reg};
   assign carry[0] = 1'b1;

   for (genvar i = 0; i <= N; i++) begin : g_sub
      assign diff[i]    = t[i] ^ bn[i] ^ carry[i];
      assign carry[i+1] = (t[i] & bn[i]) | (carry[i] & (t[i] ^ bn[i]));
   end

   assign ge = carry[N+1];

   always_comb begin
      p_nxt      = ge ? diff : t;
      quo_nxt    = quo << 1;
      quo_nxt[0] = ge;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      early     = 1'b0;
      step      = 1'b0;
      finish    = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            if (state == S_DONE) state_nxt = S_IDLE;
            if (start) begin
               accept = 1'b1;
               if (hi_ge_b) begin
                  early     = 1'b1;
                  state_nxt = S_DONE;
               end else begin
                  state_nxt = S_RUN;
               end
            end
         end
         S_RUN: begin
            step = 1'b1;
            if (cnt == LAST) begin
               finish    = 1'b1;
               state_nxt = S_DONE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign busy = (state == S_RUN);
   assign done = (state == S_DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         p     <= '0;
         lo_sr <= '0;
         quo   <= '0;
         b_reg <= '0;
         cnt   <= '0;
         q     <= '0;
         r     <= '0;
         ovf   <= 1'b0;
         div0  <= 1'b0;
      end else begin
         if (accept) begin
            p     <= {1'b0, a[2*N-1:N]};
            lo_sr <= a[N-1:0];
            quo   <= '0;
            b_reg <= b;
            cnt   <= '0;
         end
         if (step) begin
            p     <= p_nxt;
            lo_sr <= lo_sr << 1;
            quo   <= quo_nxt;
            cnt   <= cnt + CW'(1);
         end
         if (early) begin
            q    <= '1;
            r    <= '0;
            ovf  <= 1'b1;
            div0 <= (b == '0);
         end
         if (finish) begin
            q    <= quo_nxt;
            r    <= p_nxt[N-1:0];
            ovf  <= 1'b0;
            div0 <= 1'b0;
         end
      end
   end

   // The no-overflow precondition keeps the partial remainder below b, so its top bit stays clear.
   assert property (@(posedge clk) disable iff (rst) (state == S_RUN) |-> !p[N]);

endmodule

// File: tb/tb_u_seqdiv16_8.sv
// Directed and randomised bench for u_seqdiv16_8: latency, busy window, results and handshake corners.
module tb_u_seqdiv16_8;
   localparam int N = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic [2*N-1:0] a;
   logic [N-1:0]   b;
   logic           busy;
   logic           done;
   logic [N-1:0]   q;
   logic [N-1:0]   r;
   logic           ovf;
   logic           div0;

   int n_checks = 0;
   int n_pass   = 0;

   logic [2*N+1:0] exp_q[$];

   u_seqdiv16_8 #(.N(N)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .q     (q),
      .r     (r),
      .ovf   (ovf),
      .div0  (div0)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs === expv) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
   endtask

   function automatic logic [2*N+1:0] pack(input logic o, input logic z,
                                           input logic [N-1:0] qv, input logic [N-1:0] rv);
      return {o, z, qv, rv};
   endfunction

   function automatic logic [2*N+1:0] model(input logic [2*N-1:0] av, input logic [N-1:0] bv);
      logic [2*N-1:0] qq, rr;
      if (av[2*N-1:N] >= bv) return pack(1'b1, bv == '0, '1, '0);
      qq = av / {{N{1'b0}}, bv};
      rr = av % {{N{1'b0}}, bv};
      return pack(1'b0, 1'b0, qq[N-1:0], rr[N-1:0]);
   endfunction

   // Every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (exp_q.size() == 0) check("no_extra_done", {31'b0, done}, 32'd0);
         else check("result", {14'b0, ovf, div0, q, r}, {14'b0, exp_q.pop_front()});
      end
   end

   // Called at a negedge; returns at the negedge of the done cycle (or on timeout).
   task automatic op(input logic [2*N-1:0] av, input logic [N-1:0] bv,
                     input logic [2*N+1:0] expv, input int exp_lat, input string tag);
      int lat;
      int busy_cyc;
      a     = av;
      b     = bv;
      start = 1'b1;
      exp_q.push_back(expv);
      @(negedge clk);
      start    = 1'b0;
      lat      = 1;
      busy_cyc = 0;
      while (!done && lat < 30) begin
         if (busy) busy_cyc++;
         @(negedge clk);
         lat++;
      end
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_busy_cycles"}, busy_cyc, exp_lat - 1);
      check({tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_busy"}, {31'b0, busy}, 32'd0);
      check({tag, "_done"}, {31'b0, done}, 32'd0);
      check({tag, "_q"},    {24'b0, q},    32'd0);
      check({tag, "_r"},    {24'b0, r},    32'd0);
      check({tag, "_ovf"},  {31'b0, ovf},  32'd0);
      check({tag, "_div0"}, {31'b0, div0}, 32'd0);
   endtask

   initial begin
      logic [2*N-1:0] av;
      logic [N-1:0]   bv;
      logic [2*N+1:0] ev;

      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      repeat (3) @(negedge clk);
      check_cleared("reset");
      rst = 1'b0;

      @(negedge clk); op(16'd100,  8'd7,    pack(0, 0, 8'd14,  8'd2), 9, "basic");
      @(negedge clk); op(16'hFE01, 8'hFF,   pack(0, 0, 8'hFF,  8'h00), 9, "max_fe01");
      @(negedge clk); op(16'h00FF, 8'h01,   pack(0, 0, 8'hFF,  8'h00), 9, "max_00ff");
      @(negedge clk); op(16'h1234, 8'h00,   pack(1, 1, 8'hFF,  8'h00), 1, "div0");
      @(negedge clk); op(16'h0700, 8'h07,   pack(1, 0, 8'hFF,  8'h00), 1, "ovf");

      // Back-to-back: each following start lands in the previous done cycle.
      @(negedge clk); op(16'd1000, 8'd9,    pack(0, 0, 8'd111, 8'd1), 9, "b2b_first");
      op(16'd50, 8'd5,                      pack(0, 0, 8'd10,  8'd0), 9, "b2b_second");
      op(16'h1234, 8'h00,                   pack(1, 1, 8'hFF,  8'h00), 1, "b2b_div0");
      op(16'd100, 8'd7,                     pack(0, 0, 8'd14,  8'd2), 9, "b2b_after_early");

      // start held through RUN with changing operands: one done, operands from the accept cycle.
      @(negedge clk);
      a     = 16'd200;
      b     = 8'd9;
      start = 1'b1;
      exp_q.push_back(pack(0, 0, 8'd22, 8'd2));
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         a = 16'($urandom_range(0, 65535));
         b = 8'($urandom_range(0, 255));
         if (i == 8) start = 1'b0;
      end
      @(negedge clk);
      check("hold_done", {31'b0, done}, 32'd1);
      repeat (12) @(negedge clk);

      // Reset during cycle T+4 discards the operation.
      a     = 16'd100;
      b     = 8'd7;
      start = 1'b1;
      exp_q.push_back(pack(0, 0, 8'd14, 8'd2));
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      check_cleared("mid_reset");
      repeat (12) @(negedge clk);
      op(16'h0FFF, 8'h11, pack(0, 0, 8'hF0, 8'h0F), 9, "after_reset");

      repeat (200) begin
         bv = 8'($urandom_range(1, 255));
         if ($urandom_range(0, 3) == 0) av = 16'($urandom_range(0, 65535));
         else av = {8'($urandom_range(0, int'(bv) - 1)), 8'($urandom_range(0, 255))};
         ev = model(av, bv);
         @(negedge clk);
         op(av, bv, ev, ev[2*N+1] ? 1 : N + 1, "rand");
         if (!ev[2*N+1])
            check("rand_identity", 32'(int'(q) * int'(bv) + int'(r)), {16'b0, av});
      end

      repeat (3) @(negedge clk);
      check("queue_empty", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
